// File: rtl/trg_src_gen.sv
// trg_src_gen: trigger-source front end producing coincidence, external and cycled triggers
// Ports:
//   clk_in, rst_in          50 MHz clock, synchronous active-high reset
//   src_enb_in[2:0]         enables: [0] coincidence, [1] external, [2] cycled
//   hit_in, coincid_mask_in sub-detector hit flags and participation mask
//   coincid_mode_in         0 = OR of masked channels, 1 = AND of masked channels
//   ext_trg_in              asynchronous external trigger
//   cycled_period_in        cycled trigger period in us, 0 stops the generator
//   coincid_trg_out         registered coincidence level
//   ext_trg_syn_out         one-clock pulse per accepted external trigger
//   cycled_trg_out          one-clock pulse per period
module trg_src_gen #(
  parameter int NUM_HIT       = 8,
  parameter int COINC_WIN     = 10,
  parameter int EXT_MIN_WIDTH = 4,
  parameter int CLK_PER_US    = 50
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2:0]         src_enb_in,
  input  logic [NUM_HIT-1:0] hit_in,
  input  logic [NUM_HIT-1:0] coincid_mask_in,
  input  logic               coincid_mode_in,
  input  logic               ext_trg_in,
  input  logic [15:0]        cycled_period_in,
  output logic               coincid_trg_out,
  output logic               ext_trg_syn_out,
  output logic               cycled_trg_out
);
  localparam int CW = $clog2(COINC_WIN + 1);
  localparam int EW = $clog2(EXT_MIN_WIDTH + 1);
  localparam int PW = $clog2(CLK_PER_US + 1);
  typedef enum logic [1:0] {EXT_IDLE, EXT_CHECK, EXT_WAIT_LOW} ext_st_t;
  logic [NUM_HIT-1:0] hit_dly_q, hit_dly_d, stretched;
  logic [CW-1:0]      str_q [NUM_HIT];
  logic [CW-1:0]      str_d [NUM_HIT];
  logic               coincid_q, coincid_d, cond;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, ext_s;
  ext_st_t            ext_st_q, ext_st_d;
  logic [EW-1:0]      ext_cnt_q, ext_cnt_d;
  logic               ext_pulse_q, ext_pulse_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [15:0]        per_cnt_q, per_cnt_d;
  logic               cyc_pulse_q, cyc_pulse_d, cyc_en, us_tick, fire;
  always_comb begin
    hit_dly_d = hit_in;
    for (int i = 0; i < NUM_HIT; i++) begin
      stretched[i] = str_q[i] != '0;
      str_d[i] = !src_enb_in[0]               ? '0 :
                 (hit_in[i] & ~hit_dly_q[i])  ? CW'(COINC_WIN) :
                 stretched[i]                 ? str_q[i] - CW'(1) : str_q[i];
    end
    // AND mode treats unmasked channels as satisfied; an empty mask never fires
    cond = (coincid_mask_in == '0) ? 1'b0 :
           coincid_mode_in         ? ((stretched | ~coincid_mask_in) == '1) :
                                     |(stretched & coincid_mask_in);
    coincid_d = cond & src_enb_in[0];
  end
  always_comb begin
    sync1_d     = ext_trg_in;
    sync2_d     = sync1_q;
    ext_s       = sync2_q;
    ext_st_d    = ext_st_q;
    ext_cnt_d   = ext_cnt_q;
    ext_pulse_d = 1'b0;
    if (!src_enb_in[1]) begin
      ext_st_d  = EXT_IDLE;
      ext_cnt_d = '0;
    end else begin
      unique case (ext_st_q)
        EXT_IDLE: if (ext_s) begin
          ext_st_d  = EXT_CHECK;
          ext_cnt_d = EW'(1);
        end
        EXT_CHECK: if (!ext_s) ext_st_d = EXT_IDLE;
          else if (ext_cnt_q == EW'(EXT_MIN_WIDTH - 1)) begin
            ext_pulse_d = 1'b1;
            ext_st_d    = EXT_WAIT_LOW;
          end else ext_cnt_d = ext_cnt_q + EW'(1);
        EXT_WAIT_LOW: if (!ext_s) ext_st_d = EXT_IDLE;
        default: ext_st_d = EXT_IDLE;
      endcase
    end
  end
  always_comb begin
    cyc_en      = src_enb_in[2] && (cycled_period_in != '0);
    us_tick     = pre_q == PW'(CLK_PER_US - 1);
    pre_d       = (!cyc_en || us_tick) ? '0 : pre_q + PW'(1);
    // >= so that a period lowered below the running count fires on the next tick
    fire        = cyc_en && us_tick && (({1'b0, per_cnt_q} + 17'd1) >= {1'b0, cycled_period_in});
    per_cnt_d   = (!cyc_en || fire) ? '0 : us_tick ? per_cnt_q + 16'd1 : per_cnt_q;
    cyc_pulse_d = fire;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_dly_q   <= '0;
      for (int i = 0; i < NUM_HIT; i++) str_q[i] <= '0;
      coincid_q   <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      ext_st_q    <= EXT_IDLE;
      ext_cnt_q   <= '0;
      ext_pulse_q <= 1'b0;
      pre_q       <= '0;
      per_cnt_q   <= '0;
      cyc_pulse_q <= 1'b0;
    end else begin
      hit_dly_q   <= hit_dly_d;
      for (int i = 0; i < NUM_HIT; i++) str_q[i] <= str_d[i];
      coincid_q   <= coincid_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      ext_st_q    <= ext_st_d;
      ext_cnt_q   <= ext_cnt_d;
      ext_pulse_q <= ext_pulse_d;
      pre_q       <= pre_d;
      per_cnt_q   <= per_cnt_d;
      cyc_pulse_q <= cyc_pulse_d;
    end
  end
  assign coincid_trg_out = coincid_q;
  assign ext_trg_syn_out = ext_pulse_q;
  assign cycled_trg_out  = cyc_pulse_q;
endmodule

// File: tb/tb_trg_src_gen.sv
// tb_trg_src_gen: randomized scoreboard bench for trg_src_gen against a time-based reference model
module tb_trg_src_gen;
  localparam int WIN = 10, MINW = 4, CPU = 50;
  logic        clk_in = 1'b0, rst_in;
  logic [2:0]  src_enb_in;
  logic [7:0]  hit_in, coincid_mask_in;
  logic        coincid_mode_in, ext_trg_in;
  logic [15:0] cycled_period_in;
  logic        coincid_trg_out, ext_trg_syn_out, cycled_trg_out;
  int          n_cmp = 0, n_bad = 0, t = 0;
  logic [2:0]  exp_q [$];
  int          last_rise [8];
  logic [7:0]  hit_prev;
  logic        e1, e2;
  int          run, ph, ticks;
  always #10 clk_in = ~clk_in;
  trg_src_gen #(.NUM_HIT(8), .COINC_WIN(WIN), .EXT_MIN_WIDTH(MINW), .CLK_PER_US(CPU)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .src_enb_in(src_enb_in), .hit_in(hit_in),
    .coincid_mask_in(coincid_mask_in), .coincid_mode_in(coincid_mode_in),
    .ext_trg_in(ext_trg_in), .cycled_period_in(cycled_period_in),
    .coincid_trg_out(coincid_trg_out), .ext_trg_syn_out(ext_trg_syn_out),
    .cycled_trg_out(cycled_trg_out));
  // Reference model: each posedge t yields the outputs expected just after that edge.
  // A channel is stretched after edge m if it rose at edge r with m-r < WIN and stayed enabled;
  // the external trigger fires on the MINW-th consecutive enabled high sample of the
  // twice-delayed input; the cycled generator counts elapsed clocks since enable.
  always @(posedge clk_in) begin : model
    logic [2:0] ex;
    logic [7:0] st;
    logic       cond;
    ex = 3'b000;
    if (rst_in) begin
      for (int i = 0; i < 8; i++) last_rise[i] = -1000;
      hit_prev = 8'h00; e1 = 1'b0; e2 = 1'b0; run = 0; ph = 0; ticks = 0;
    end else begin
      for (int i = 0; i < 8; i++) st[i] = (t - 1 - last_rise[i]) < WIN;
      cond = (coincid_mask_in == 8'h00) ? 1'b0 :
             coincid_mode_in ? ((st & coincid_mask_in) == coincid_mask_in) : |(st & coincid_mask_in);
      ex[0] = cond & src_enb_in[0];
      for (int i = 0; i < 8; i++)
        if (!src_enb_in[0]) last_rise[i] = -1000;
        else if (hit_in[i] && !hit_prev[i]) last_rise[i] = t;
      hit_prev = hit_in;
      run = !src_enb_in[1] ? 0 : e2 ? run + 1 : 0;
      ex[1] = (run == MINW);
      e2 = e1;
      e1 = ext_trg_in;
      if (!src_enb_in[2] || cycled_period_in == 16'd0) begin
        ph = 0; ticks = 0;
      end else begin
        ph++;
        if (ph % CPU == 0) begin
          if (ticks + 1 >= int'(cycled_period_in)) begin ex[2] = 1'b1; ticks = 0; end
          else ticks++;
        end
      end
    end
    t++;
    exp_q.push_back(ex);
  end
  function automatic void chk(string nm, logic act, logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, t, act, req);
    end
  endfunction
  always @(posedge clk_in) begin : monitor
    logic [2:0] ex;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty at edge %0d: got no entry, expected one", t);
    end else begin
      ex = exp_q.pop_front();
      chk("coincid_trg_out", coincid_trg_out, ex[0]);
      chk("ext_trg_syn_out", ext_trg_syn_out, ex[1]);
      chk("cycled_trg_out", cycled_trg_out, ex[2]);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk_in);
  endtask
  initial begin
    int k;
    rst_in = 1'b1; src_enb_in = 3'b111; hit_in = 8'hff; coincid_mask_in = 8'hff;
    coincid_mode_in = 1'b0; ext_trg_in = 1'b1; cycled_period_in = 16'd1;
    cyc(5);
    rst_in = 1'b0; hit_in = 8'h00; ext_trg_in = 1'b0; cycled_period_in = 16'd0;
    cyc(20);
    ext_trg_in = 1'b1; cyc(4);
    rst_in = 1'b1; ext_trg_in = 1'b0; cyc(1);
    rst_in = 1'b0; cyc(20);
    coincid_mask_in = 8'h05; coincid_mode_in = 1'b1;
    hit_in = 8'h01; cyc(6);  hit_in = 8'h05; cyc(20); hit_in = 8'h00; cyc(5);
    hit_in = 8'h01; cyc(12); hit_in = 8'h05; cyc(20); hit_in = 8'h00; cyc(5);
    coincid_mode_in = 1'b0;
    hit_in = 8'h01; cyc(6);  hit_in = 8'h05; cyc(20); hit_in = 8'h00; cyc(20);
    coincid_mask_in = 8'h00; hit_in = 8'hff; cyc(15); hit_in = 8'h00; cyc(5);
    ext_trg_in = 1'b1; cyc(2);  ext_trg_in = 1'b0; cyc(10);
    ext_trg_in = 1'b1; cyc(20); ext_trg_in = 1'b0; cyc(10);
    ext_trg_in = 1'b1; cyc(20); ext_trg_in = 1'b0; cyc(10);
    cycled_period_in = 16'd3;   cyc(500);
    cycled_period_in = 16'd0;   cyc(100);
    cycled_period_in = 16'd100; cyc(CPU * 60 + 20);
    cycled_period_in = 16'd10;  cyc(1200);
    cycled_period_in = 16'd0;   cyc(10);
    src_enb_in = 3'b000; hit_in = 8'hff; coincid_mask_in = 8'hff; ext_trg_in = 1'b1;
    cycled_period_in = 16'd2; cyc(300);
    src_enb_in = 3'b010; cyc(30); ext_trg_in = 1'b0; cyc(10);
    src_enb_in = 3'b111; hit_in = 8'h00; cyc(10);
    repeat (5000) begin
      if ($urandom_range(0, 3) == 0) begin k = $urandom_range(0, 7); hit_in[k] = ~hit_in[k]; end
      if ($urandom_range(0, 7) == 0) ext_trg_in = ~ext_trg_in;
      if ($urandom_range(0, 99) == 0) coincid_mask_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) coincid_mode_in = ~coincid_mode_in;
      if ($urandom_range(0, 199) == 0) src_enb_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) cycled_period_in = 16'($urandom_range(0, 4));
      rst_in = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    rst_in = 1'b0; cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
